// File: rtl/mem_access_stage.sv
// Memory-access stage: turns M-stage loads/stores into one ready-handshaked bus
// transaction with pipeline stall, alignment check and a 255-cycle bus timeout.
// Optional feature macro: MEM_ACCESS_SUBWORD_EN (halfword/byte accesses); undefined = word-only.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  LoadTypeM,
  input  logic [1:0]  StoreTypeM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] RDM,
  output logic        StallM,
  output logic        AdEM,
  output logic        BusErrM
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  // The counter reaches 255 on the cycle the FSM gives up, i.e. after 255 REQ cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'd254;

  state_t      r_state, w_next;
  logic        r_we, r_is_read, r_bus_err;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata, r_rdm;
  logic [2:0]  r_load_type;
  logic [1:0]  r_off;
  logic [7:0]  r_cnt;

  logic        w_access_req, w_misaligned, w_access;
  logic        w_stall, w_accept, w_complete, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_ext;

  assign w_access_req = MemReadM | MemWriteM;

`ifdef MEM_ACCESS_SUBWORD_EN
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Simultaneous read+write is a write, so store rules take priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = WriteDataM;
    if (MemWriteM) begin
      case (StoreTypeM)
        2'b01: begin
          w_misaligned = ALUoutM[0];
          w_be         = ALUoutM[1] ? 4'b1100 : 4'b0011;
          w_wdata      = {2{WriteDataM[15:0]}};
        end
        2'b10: begin
          w_be    = 4'b0001 << ALUoutM[1:0];
          w_wdata = {4{WriteDataM[7:0]}};
        end
        default: w_misaligned = |ALUoutM[1:0];
      endcase
    end else begin
      case (LoadTypeM)
        3'b001, 3'b010: w_misaligned = ALUoutM[0];
        3'b011, 3'b100: w_misaligned = 1'b0;
        default:        w_misaligned = |ALUoutM[1:0];
      endcase
    end
  end

  always_comb begin
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_byte = mem_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    case (r_load_type)
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_ext = {16'h0000, w_half};
      3'b011:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'h000000, w_byte};
      default: w_load_ext = mem_rdata;
    endcase
  end
`else
  logic w_unused;

  assign w_misaligned = |ALUoutM[1:0];
  assign w_be         = 4'b1111;
  assign w_wdata      = WriteDataM;
  assign w_load_ext   = mem_rdata;
  assign w_unused     = ^{LoadTypeM, StoreTypeM, r_load_type, r_off};
`endif

  assign w_access = w_access_req & ~w_misaligned;

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_accept   = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_next   = S_REQ;
          w_stall  = 1'b1;
          w_accept = 1'b1;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (mem_ready) begin
          w_next     = S_DONE;
          w_complete = 1'b1;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_be        <= 4'b0000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rdm       <= 32'h0;
      r_bus_err   <= 1'b0;
      r_is_read   <= 1'b0;
      r_load_type <= 3'b000;
      r_off       <= 2'b00;
      r_cnt       <= 8'h00;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state   <= w_next;
      r_bus_err <= w_timeout;
      if (w_accept) begin
        r_we        <= MemWriteM;
        r_is_read   <= ~MemWriteM;
        r_be        <= MemWriteM ? w_be : 4'b1111;
        r_addr      <= {ALUoutM[31:2], 2'b00};
        r_wdata     <= w_wdata;
        r_load_type <= LoadTypeM;
        r_off       <= ALUoutM[1:0];
        r_cnt       <= 8'h00;
      end
      if (r_state == S_REQ && !mem_ready) r_cnt <= r_cnt + 8'd1;
      if (w_complete && r_is_read) r_rdm <= w_load_ext;
      if (w_timeout) r_rdm <= 32'h0;
    end
  end

  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign RDM       = r_rdm;
  assign BusErrM   = r_bus_err;
  // Stall is combinational on the M inputs, so it is masked while reset is held.
  assign StallM    = w_stall & reset;
  assign AdEM      = w_access_req & w_misaligned;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge; reset  in  1  asynchronous active-low reset.
REQ-002 SHALL have from E/M: MemReadM in 1, MemWriteM in 1, LoadTypeM in 3 (000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu), StoreTypeM in 2 (00 sw, 01 sh, 10 sb), ALUoutM in 32 byte address, WriteDataM in 32 store data.
REQ-003 SHALL have memory bus: mem_req out 1, mem_we out 1, mem_addr out 32 word-aligned, mem_be out 4 byte enables, mem_wdata out 32, mem_ready in 1, mem_rdata in 32.
REQ-004 SHALL have to pipeline and M/W register: RDM out 32 extended load data, StallM out 1 freeze F/D/E/M, AdEM out 1 misaligned address, BusErrM out 1 bus timeout.

Function
REQ-005 SHALL run FSM IDLE, REQ, DONE; an access is MemReadM|MemWriteM with AdEM=0.
REQ-006 IDLE: on access, load bus outputs from M inputs, go REQ; StallM=1 this cycle; otherwise stay IDLE, StallM=0.
REQ-007 REQ: mem_req=1, StallM=1, bus outputs held constant until mem_ready=1, then go DONE; mem_ready is ignored outside REQ.
REQ-008 On mem_ready in REQ during a read, SHALL register extended mem_rdata into RDM; a write leaves RDM unchanged.
REQ-009 DONE: mem_req=0, StallM=0 for exactly one cycle so M/W samples RDM, then IDLE; minimum access latency is 3 cycles (IDLE, REQ, DONE).
REQ-010 mem_addr = {ALUoutM[31:2],2'b00}; mem_we=MemWriteM; mem_wdata replicates store data per lane (sh: {2{h}}, sb: {4{b}}).
REQ-011 mem_be: sw 1111; sh 0011 at offset 0, 1100 at offset 2; sb one-hot 0001<<ALUoutM[1:0]; reads drive 1111.
REQ-012 Load extension: select lane by ALUoutM[1:0]; lh/lb sign-extend, lhu/lbu zero-extend, lw passes through.
REQ-013 AdEM combinational: lw/sw with ALUoutM[1:0]!=0, or lh/lhu/sh with ALUoutM[0]=1; on AdEM, no bus cycle, StallM=0, RDM unchanged.
REQ-014 An 8-bit timeout counter SHALL clear on entering REQ and increment each REQ cycle; at 255 without mem_ready, set BusErrM=1, RDM=0, go DONE.
REQ-015 BusErrM SHALL be a one-cycle pulse asserted during DONE following timeout only.
REQ-016 MemReadM and MemWriteM both 1 SHALL be treated as write.

Reset
REQ-017 On reset low, at once: state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, RDM=0, BusErrM=0, counter=0, StallM=0.
REQ-018 Reset during REQ SHALL abandon the transaction without completion; first access after release starts from IDLE.

Configuration
REQ-019 Macro MEM_ACCESS_SUBWORD_EN: defined, all LoadTypeM/StoreTypeM encodings per REQ-011..013.
REQ-020 Undefined: every access treated as lw/sw, mem_be=1111, RDM=mem_rdata, AdEM only on ALUoutM[1:0]!=0.

Verification
REQ-021 lw addr 0x0000_0010, mem_ready one cycle after mem_req, rdata 0xDEAD_BEEF -> StallM=1 two cycles, RDM=0xDEADBEEF in DONE, StallM=0.
REQ-022 lb addr 0x13, rdata 0x80FF_0000 -> mem_be=1111, RDM=0xFFFF_FF80; lbu same -> RDM=0x0000_0080.
REQ-023 sh addr 0x22, WriteDataM 0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x20.
REQ-024 lw addr 0x06 -> AdEM=1, mem_req never asserted, StallM=0.
REQ-025 lw with mem_ready held 0 -> after 255 REQ cycles BusErrM=1 one cycle, RDM=0, FSM IDLE next cycle.
REQ-026 reset low mid-REQ with mem_ready=0 -> mem_req=0 immediately, RDM=0, state IDLE after release.
